// File: rtl/bram_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// bram_rd_pkg
// Shared definitions for the BRAM stream reader:
//   - default data / address widths
//   - reader state enumeration (IDLE, RUN, DRAIN)
//   - can_issue(): the read-issue occupancy rule used by the controller
// Optional feature macro used by the slice: BRAM_RD_STALL_CNT_EN
// -----------------------------------------------------------------------------
package bram_rd_pkg;

    localparam int RAM_WIDTH_DEF     = 32'sd24;
    localparam int RAM_ADDR_BITS_DEF = 32'sd16;
    localparam int STALL_CNT_W       = 32'sd32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // A new read may issue only if the words already buffered plus the read
    // in flight, minus the word leaving this cycle, still leave a free slot
    // in the 2-entry buffer for the data that will return next cycle.
    function automatic logic can_issue(input logic [1:0] count,
                                       input logic       in_flight,
                                       input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, count} + {2'b00, in_flight};
        return (occ < (3'd2 + {2'b00, pop}));
    endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// -----------------------------------------------------------------------------
// bram_stream_reader_if
// Bundles the command, BRAM read-port and output-stream signals of the reader.
//   command : start, base_addr, length          (environment -> reader)
//   status  : busy, done                          (reader -> environment)
//   BRAM    : ra (reader -> RAM), rd_data (RAM -> reader, one clock after ra)
//   stream  : out_data, out_valid, out_last (reader -> consumer), out_ready
//   stall_cnt (32 bit) exists only when BRAM_RD_STALL_CNT_EN is defined
// Modports: master = the reader, slave = the environment driving it.
// -----------------------------------------------------------------------------
interface bram_stream_reader_if
    import bram_rd_pkg::*;
#(
    parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) ();

    logic                     start;
    logic [RAM_ADDR_BITS-1:0] base_addr;
    logic [RAM_ADDR_BITS:0]   length;
    logic [RAM_ADDR_BITS-1:0] ra;
    logic [RAM_WIDTH-1:0]     rd_data;
    logic [RAM_WIDTH-1:0]     out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic                     busy;
    logic                     done;
`ifdef BRAM_RD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0]   stall_cnt;
`endif

    modport master (
`ifdef BRAM_RD_STALL_CNT_EN
        output stall_cnt,
`endif
        input  start,
        input  base_addr,
        input  length,
        output ra,
        input  rd_data,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last,
        output busy,
        output done
    );

    modport slave (
`ifdef BRAM_RD_STALL_CNT_EN
        input  stall_cnt,
`endif
        output start,
        output base_addr,
        output length,
        input  ra,
        output rd_data,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last,
        input  busy,
        input  done
    );

endinterface

// File: rtl/bram_stream_reader_skid.sv
// -----------------------------------------------------------------------------
// bram_rd_skid
// Two-entry output FIFO. Entry 0 is always the head, so the head word stays
// put while the consumer stalls.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   push_i        : write push_data_i this cycle
//   push_data_i   : word to store (W bits)
//   pop_i         : consumer takes the head word (ignored when empty)
//   head_o        : head word
//   count_o       : number of stored words (0..2)
//   valid_o       : FIFO not empty (registered)
// -----------------------------------------------------------------------------
module bram_rd_skid #(
    parameter int W = 32'sd25
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o,
    output logic         valid_o
);

    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic [1:0]   count_q, count_d;
    logic         valid_q;
    logic         pop_s;

    // Next-state of the two entries and the occupancy count.
    always_comb begin
        pop_s   = pop_i && (count_q != 2'd0);
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        case ({push_i, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    ent0_d  = push_data_i;
                    count_d = 2'd1;
                end else if (count_q == 2'd1) begin
                    ent1_d  = push_data_i;
                    count_d = 2'd2;
                end else begin
                    // Full: the controller never issues a read that could land here.
                    count_d = count_q;
                end
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    ent0_d = ent1_q;
                end else begin
                    ent0_d = ent0_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = push_data_i;
                end else begin
                    ent0_d = push_data_i;
                end
                count_d = count_q;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Entry and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent0_q  <= {W{1'b0}};
            ent1_q  <= {W{1'b0}};
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
            valid_q <= (count_d != 2'd0);
        end
    end

    assign head_o  = ent0_q;
    assign count_o = count_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
// Streams a burst of `length` words starting at `base_addr` out of a BRAM with
// a one-clock read latency, through a 2-entry buffer, onto a valid/ready stream.
// Ports:
//   clk      : clock, all state on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : bram_stream_reader_if.master (command, status, BRAM port, stream)
// Parameters: RAM_WIDTH (data bits), RAM_ADDR_BITS (address bits).
// Optional: define BRAM_RD_STALL_CNT_EN to add bus.stall_cnt, a saturating
// count of busy cycles in which a word waits on the consumer.
// -----------------------------------------------------------------------------
module bram_stream_reader
    import bram_rd_pkg::*;
#(
    parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bram_stream_reader_if.master bus
);

    // Each buffered word carries a "last" tag in its top bit.
    localparam int ENTRY_W = RAM_WIDTH + 32'sd1;
    localparam logic [RAM_ADDR_BITS:0]   REM_ONE  = {{RAM_ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [RAM_ADDR_BITS:0]   REM_ZERO = {(RAM_ADDR_BITS + 1){1'b0}};
    localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = {{(RAM_ADDR_BITS - 1){1'b0}}, 1'b1};

    rd_state_e                state_q;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [RAM_ADDR_BITS:0]   rem_q, rem_d;
    logic                     in_flight_q;
    logic                     in_flight_last_q;
    logic                     busy_q;
    logic                     done_q;

    logic                     start_ok_s;
    logic                     pop_s;
    logic                     final_pop_s;
    logic                     issue_s;
    logic                     last_issue_s;
    logic [ENTRY_W-1:0]       head_s;
    logic [1:0]               fifo_count_s;
    logic                     fifo_valid_s;

    // Handshake decode and read-issue decision.
    always_comb begin
        start_ok_s   = (state_q == IDLE) && bus.start;
        pop_s        = fifo_valid_s && bus.out_ready;
        final_pop_s  = pop_s && head_s[RAM_WIDTH];
        if (state_q == RUN) begin
            issue_s = can_issue(fifo_count_s, in_flight_q, pop_s);
        end else begin
            issue_s = 1'b0;
        end
        last_issue_s = issue_s && (rem_q == REM_ONE);
        // Plain binary add: the top address rolls over to zero.
        addr_d       = addr_q + ADDR_ONE;
        rem_d        = rem_q - REM_ONE;
    end

    // Reader FSM with its address/count registers and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            addr_q           <= {RAM_ADDR_BITS{1'b0}};
            rem_q            <= REM_ZERO;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            done_q           <= 1'b0;
            in_flight_q      <= issue_s;
            in_flight_last_q <= last_issue_s;
            if (issue_s) begin
                addr_q <= addr_d;
                rem_q  <= rem_d;
            end
            case (state_q)
                IDLE: begin
                    if (start_ok_s) begin
                        if (bus.length != REM_ZERO) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            addr_q  <= bus.base_addr;
                            rem_q   <= bus.length;
                        end else begin
                            // Empty burst: nothing to read, just report completion.
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last_issue_s) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (final_pop_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Data returns one clock after the read issued; push it with its last tag.
    bram_rd_skid #(
        .W (ENTRY_W)
    ) u_skid (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (in_flight_q),
        .push_data_i ({in_flight_last_q, bus.rd_data}),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (fifo_count_s),
        .valid_o     (fifo_valid_s)
    );

    assign bus.ra        = addr_q;
    assign bus.out_data  = head_s[RAM_WIDTH-1:0];
    assign bus.out_valid = fifo_valid_s;
    assign bus.out_last  = fifo_valid_s & head_s[RAM_WIDTH];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef BRAM_RD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Saturating count of busy cycles where a word waits on the consumer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 32'd0;
        end else if (start_ok_s) begin
            stall_cnt_q <= 32'd0;
        end else if (busy_q && fifo_valid_s && !bus.out_ready &&
                     (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_reader
// Directed + randomized bench for bram_stream_reader. A word-addressed memory
// image feeds a one-clock-latency BRAM model; every accepted burst appends the
// words mem[(base+i) mod 2^16] to an expected-beat queue that the stream
// monitor drains in order.
// -----------------------------------------------------------------------------
module tb_bram_stream_reader;

    localparam int AW = 16;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    bram_stream_reader_if #(.RAM_WIDTH(DW), .RAM_ADDR_BITS(AW)) bus ();

    bram_stream_reader #(.RAM_WIDTH(DW), .RAM_ADDR_BITS(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    logic [DW-1:0] mem [0:65535];

    // BRAM read port: registered read, data valid one clock after the address.
    always @(posedge clk) bus.rd_data <= mem[bus.ra];

    logic [DW-1:0] exp_data_q [$];
    bit            exp_last_q [$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            beats_seen  = 0;
    int            stall_seen  = 0;
    int            stall_base  = 0;
    int            done_seen   = 0;
    int            rdy_mode    = 0;
    int            pat_i       = 0;
    logic          prev_hold   = 1'b0;
    logic [DW-1:0] prev_data   = '0;
    logic          prev_last   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        if (bus.out_valid && bus.out_ready) begin
            beats_seen++;
            chk("beat_expected", 32'(exp_data_q.size() != 0), 32'd1);
            if (exp_data_q.size() != 0) begin
                chk("beat_data", 32'(bus.out_data), 32'(exp_data_q.pop_front()));
                chk("beat_last", 32'(bus.out_last), 32'(exp_last_q.pop_front()));
            end
        end
        if (prev_hold) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data", 32'(bus.out_data), 32'(prev_data));
            chk("hold_last", 32'(bus.out_last), 32'(prev_last));
        end
        prev_hold = reset_n && bus.out_valid && !bus.out_ready;
        prev_data = bus.out_data;
        prev_last = bus.out_last;
        if (bus.busy && bus.out_valid && !bus.out_ready) stall_seen++;
        if (bus.done) done_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        case (rdy_mode)
            0: bus.out_ready = 1'b1;
            1: begin
                bus.out_ready = ((pat_i % 3) == 0);
                pat_i++;
            end
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        monitor();
    endtask

    task automatic start_burst(input logic [AW-1:0] base, input logic [AW:0] len);
        logic [AW-1:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = base + i[AW-1:0];
            exp_data_q.push_back(mem[a]);
            exp_last_q.push_back(i == int'(len) - 1);
        end
        stall_base    = stall_seen;
        bus.base_addr = base;
        bus.length    = len;
        bus.start     = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.done && n < 400);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        chk({tag, "_drained"}, 32'(exp_data_q.size()), 32'd0);
`ifdef BRAM_RD_STALL_CNT_EN
        chk({tag, "_stall_cnt"}, bus.stall_cnt, 32'(stall_seen - stall_base));
`endif
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_ra"}, 32'(bus.ra), 32'd0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_last"}, 32'(bus.out_last), 32'd0);
        chk({tag, "_data"}, 32'(bus.out_data), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] b;
        int d0;
        int b0;
        int n;

        for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.out_ready = 1'b1;

        // Reset state.
        tick();
        tick();
        chk_cleared("reset");
`ifdef BRAM_RD_STALL_CNT_EN
        chk("reset_stall_cnt", bus.stall_cnt, 32'd0);
`endif
        reset_n = 1'b1;
        tick();
        tick();

        // Base 0x0010, length 4, consumer always ready: latency and done timing.
        rdy_mode = 0;
        start_burst(16'h0010, 17'd4);
        tick();
        chk("lat_e0_valid", 32'(bus.out_valid), 32'd0);
        chk("lat_e0_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("lat_e1_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("lat_e2_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_first_data", 32'(bus.out_data), 32'(mem[16'h0010]));
        for (int i = 0; i < 4; i++) tick();
        chk("b4_done", 32'(bus.done), 32'd1);
        chk("b4_busy", 32'(bus.busy), 32'd0);
        chk("b4_queue", 32'(exp_data_q.size()), 32'd0);
        tick();
        chk("b4_done_pulse", 32'(bus.done), 32'd0);

        // Address wrap at the top of the address space.
        start_burst(16'hFFFE, 17'd4);
        wait_done("wrap");

        // Length 8 with the consumer pattern 1,0,0,1,0,0,...
        rdy_mode = 1;
        pat_i    = 0;
        b        = 16'($urandom);
        start_burst(b, 17'd8);
        wait_done("stall8");

        // Zero-length start: done once, never busy, no beats.
        rdy_mode = 0;
        tick();
        d0 = done_seen;
        bus.base_addr = 16'h0100;
        bus.length    = 17'd0;
        bus.start     = 1'b1;
        tick();
        chk("len0_done", 32'(bus.done), 32'd1);
        chk("len0_busy", 32'(bus.busy), 32'd0);
        chk("len0_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("len0_busy_after", 32'(bus.busy), 32'd0);
        end
        chk("len0_done_once", 32'(done_seen - d0), 32'd1);

        // Reset in the middle of a 10-word burst.
        b = 16'($urandom);
        start_burst(b, 17'd10);
        b0 = beats_seen;
        n  = 0;
        do begin
            tick();
            n++;
        end while ((beats_seen - b0) < 3 && n < 50);
        chk("mid_reset_reached", 32'(beats_seen - b0), 32'd3);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_cleared("async_reset");
        exp_data_q.delete();
        exp_last_q.delete();
        prev_hold = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_reset_valid", 32'(bus.out_valid), 32'd0);
        chk("post_reset_busy", 32'(bus.busy), 32'd0);
        start_burst(16'h0020, 17'd2);
        wait_done("after_reset");

        // Start re-pulsed while busy must be ignored.
        b = 16'($urandom);
        start_burst(b, 17'd6);
        tick();
        tick();
        bus.base_addr = b + 16'h1234;
        bus.length    = 17'd3;
        bus.start     = 1'b1;
        wait_done("restart_ignored");
        for (int i = 0; i < 4; i++) tick();
        chk("restart_no_extra", 32'(bus.busy), 32'd0);

        // Randomized bursts with a random consumer.
        rdy_mode = 2;
        for (int k = 0; k < 8; k++) begin
            b = 16'($urandom);
            start_burst(b, 17'($urandom_range(1, 20)));
            wait_done("random");
        end

        rdy_mode = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("final_queue_empty", 32'(exp_data_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
